// File: rtl/snn_pe_scheduler.sv
// snn_pe_scheduler: sequencer for one dual-layer spiking PE.
// Sweeps timesteps (outer), layers, then 4-input groups (inner). Each layer
// pass is FETCH (prime the memories with group 0), ACCUM (one cycle per group,
// PE enabled, next group's address issued in parallel), then SAMPLE (capture
// the PE fire bit, report it as an event and count it per layer).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     run request pulse, ignored while busy
//   busy, done                run in progress / one-cycle completion pulse
//   w_addr, w_rdata           weight memory (1-cycle synchronous read)
//   s_addr, s_rdata           input-spike memory (1-cycle synchronous read)
//   pe_en, pe_layer           one-hot accumulate enable and layer select
//   pe_spike_in, pe_weight0..3  PE data, passed through from read data
//   pe_spike_out              PE fire indication for pe_layer
//   ev_valid/layer/t/spike    spike-event report, one cycle after SAMPLE
//   spk_cnt0, spk_cnt1        per-layer fire counts for the current run
module snn_pe_scheduler #(
    parameter int unsigned N_IN = 8,
    parameter int unsigned N_T  = 4,
    parameter int unsigned WA_W = $clog2(2 * (N_IN / 4)),
    parameter int unsigned SA_W = $clog2(N_T * 2 * (N_IN / 4))
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [WA_W-1:0]            w_addr,
    input  logic [31:0]                w_rdata,
    output logic [SA_W-1:0]            s_addr,
    input  logic [3:0]                 s_rdata,
    output logic [1:0]                 pe_en,
    output logic                       pe_layer,
    output logic [3:0]                 pe_spike_in,
    output logic [7:0]                 pe_weight0,
    output logic [7:0]                 pe_weight1,
    output logic [7:0]                 pe_weight2,
    output logic [7:0]                 pe_weight3,
    input  logic                       pe_spike_out,
    output logic                       ev_valid,
    output logic                       ev_layer,
    output logic [$clog2(N_T)-1:0]     ev_t,
    output logic                       ev_spike,
    output logic [$clog2(N_T+1)-1:0]   spk_cnt0,
    output logic [$clog2(N_T+1)-1:0]   spk_cnt1
);

    localparam int unsigned N_GROUPS = N_IN / 4;
    localparam int unsigned G_W      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int unsigned T_W      = $clog2(N_T);
    localparam int unsigned C_W      = $clog2(N_T + 1);

    localparam logic [G_W-1:0] G_LAST = G_W'(N_GROUPS - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(N_T - 1);
    localparam logic [C_W-1:0] C_MAX  = C_W'(N_T);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ACCUM  = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [T_W-1:0] t, t_n;
    logic           l, l_n;
    logic [G_W-1:0] g, g_n;

    logic            busy_n, done_n;
    logic [WA_W-1:0] w_addr_n;
    logic [SA_W-1:0] s_addr_n;
    logic [1:0]      pe_en_n;
    logic            pe_layer_n;
    logic            ev_valid_n, ev_layer_n, ev_spike_n;
    logic [T_W-1:0]  ev_t_n;
    logic [C_W-1:0]  cnt0_n, cnt1_n;
    int unsigned     gi;

    // Weight address of group gg in layer ll.
    function automatic logic [WA_W-1:0] w_addr_of(input logic ll, input int unsigned gg);
        return WA_W'(32'(ll) * N_GROUPS + gg);
    endfunction

    // Spike address of group gg in layer ll at timestep tt.
    function automatic logic [SA_W-1:0] s_addr_of(input logic [T_W-1:0] tt, input logic ll,
                                                  input int unsigned gg);
        return SA_W'((32'(tt) * 2 + 32'(ll)) * N_GROUPS + gg);
    endfunction

    // PE data path is a direct pass-through of the memory read ports.
    assign pe_spike_in = s_rdata;
    assign pe_weight0  = w_rdata[7:0];
    assign pe_weight1  = w_rdata[15:8];
    assign pe_weight2  = w_rdata[23:16];
    assign pe_weight3  = w_rdata[31:24];

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            t        <= '0;
            l        <= 1'b0;
            g        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            w_addr   <= '0;
            s_addr   <= '0;
            pe_en    <= '0;
            pe_layer <= 1'b0;
            ev_valid <= 1'b0;
            ev_layer <= 1'b0;
            ev_t     <= '0;
            ev_spike <= 1'b0;
            spk_cnt0 <= '0;
            spk_cnt1 <= '0;
        end else begin
            state    <= state_n;
            t        <= t_n;
            l        <= l_n;
            g        <= g_n;
            busy     <= busy_n;
            done     <= done_n;
            w_addr   <= w_addr_n;
            s_addr   <= s_addr_n;
            pe_en    <= pe_en_n;
            pe_layer <= pe_layer_n;
            ev_valid <= ev_valid_n;
            ev_layer <= ev_layer_n;
            ev_t     <= ev_t_n;
            ev_spike <= ev_spike_n;
            spk_cnt0 <= cnt0_n;
            spk_cnt1 <= cnt1_n;
        end
    end

    // Next state, loop counters, and next-cycle outputs.
    always_comb begin
        state_n    = state;
        t_n        = t;
        l_n        = l;
        g_n        = g;
        done_n     = 1'b0;
        ev_valid_n = 1'b0;
        ev_layer_n = ev_layer;
        ev_t_n     = ev_t;
        ev_spike_n = ev_spike;
        cnt0_n     = spk_cnt0;
        cnt1_n     = spk_cnt1;
        busy_n     = 1'b0;
        pe_en_n    = '0;
        pe_layer_n = pe_layer;
        w_addr_n   = w_addr;
        s_addr_n   = s_addr;
        gi         = 0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    t_n     = '0;
                    l_n     = 1'b0;
                    g_n     = '0;
                    cnt0_n  = '0;
                    cnt1_n  = '0;
                end
            end
            FETCH: begin
                state_n = ACCUM;
                g_n     = '0;
            end
            ACCUM: begin
                if (g == G_LAST) begin
                    state_n = SAMPLE;
                end else begin
                    g_n = g + G_W'(1);
                end
            end
            SAMPLE: begin
                ev_valid_n = 1'b1;
                ev_spike_n = pe_spike_out;
                ev_layer_n = l;
                ev_t_n     = t;
                // Per-layer fire counts saturate at N_T.
                if (pe_spike_out) begin
                    if (!l && spk_cnt0 != C_MAX) cnt0_n = spk_cnt0 + C_W'(1);
                    if (l && spk_cnt1 != C_MAX)  cnt1_n = spk_cnt1 + C_W'(1);
                end
                g_n = '0;
                if (!l) begin
                    l_n     = 1'b1;
                    state_n = FETCH;
                end else if (t != T_LAST) begin
                    t_n     = t + T_W'(1);
                    l_n     = 1'b0;
                    state_n = FETCH;
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so derive them from the upcoming state.
        busy_n = (state_n != IDLE);
        case (state_n)
            FETCH: begin
                pe_layer_n = l_n;
                w_addr_n   = w_addr_of(l_n, 0);
                s_addr_n   = s_addr_of(t_n, l_n, 0);
            end
            ACCUM: begin
                pe_en_n[l_n] = 1'b1;
                pe_layer_n   = l_n;
                // Prefetch the next group; hold on the last one.
                gi       = (g_n == G_LAST) ? 32'(g_n) : 32'(g_n) + 1;
                w_addr_n = w_addr_of(l_n, gi);
                s_addr_n = s_addr_of(t_n, l_n, gi);
            end
            SAMPLE: begin
                pe_layer_n = l_n;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_snn_pe_scheduler.sv
// Directed testbench for snn_pe_scheduler with default parameters
// (N_IN=8, N_T=4): synchronous memory models whose read data encodes the
// address, and a PE fire input driven per directed scenario.
module tb_snn_pe_scheduler;

    logic        clk, rst, start, busy, done;
    logic [1:0]  w_addr;
    logic [31:0] w_rdata;
    logic [3:0]  s_addr, s_rdata;
    logic [1:0]  pe_en;
    logic        pe_layer;
    logic [3:0]  pe_spike_in;
    logic [7:0]  pe_weight0, pe_weight1, pe_weight2, pe_weight3;
    logic        pe_spike_out;
    logic        ev_valid, ev_layer, ev_spike;
    logic [1:0]  ev_t;
    logic [2:0]  spk_cnt0, spk_cnt1;

    int checks = 0;
    int errors = 0;

    snn_pe_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_addr(w_addr), .w_rdata(w_rdata), .s_addr(s_addr), .s_rdata(s_rdata),
        .pe_en(pe_en), .pe_layer(pe_layer), .pe_spike_in(pe_spike_in),
        .pe_weight0(pe_weight0), .pe_weight1(pe_weight1),
        .pe_weight2(pe_weight2), .pe_weight3(pe_weight3),
        .pe_spike_out(pe_spike_out), .ev_valid(ev_valid), .ev_layer(ev_layer),
        .ev_t(ev_t), .ev_spike(ev_spike), .spk_cnt0(spk_cnt0), .spk_cnt1(spk_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories: weight byte k at address a is a*4+k; spike word at address a is a.
    always @(posedge clk) begin
        w_rdata <= {4'h0, w_addr, 2'd3, 4'h0, w_addr, 2'd2,
                    4'h0, w_addr, 2'd1, 4'h0, w_addr, 2'd0};
        s_rdata <= s_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full run; cycle c counts from the start edge. mode 0: PE never fires,
    // 1: PE always fires, 2: fires only in SAMPLE of t=2, layer 1.
    task automatic run(input int mode, input bit restart, input int exp_c0,
                       input int exp_c1, input int exp_fires);
        int p, ph, t, l, m0, m1, pt, pl, evs, fires, g;
        bit sp, psp;
        m0 = 0; m1 = 0; pt = 0; pl = 0; psp = 0; evs = 0; fires = 0;
        start = 1'b1;
        pe_spike_out = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            p  = (c - 1) / 4;
            ph = (c - 1) % 4;
            t  = p / 2;
            l  = p % 2;
            g  = ph - 1;
            sp = (c <= 32) && (ph == 3) && (mode == 1 || (mode == 2 && t == 2 && l == 1));
            pe_spike_out = (mode == 1) ? 1'b1 : sp;
            start = restart && (c == 10);

            chk("busy", 32'(busy), 32'(c <= 32));
            chk("done", 32'(done), 32'(c == 33));
            chk("ev_valid", 32'(ev_valid), 32'(c > 1 && ph == 0));
            if (c > 1 && ph == 0) begin
                chk("ev_layer", 32'(ev_layer), pl);
                chk("ev_t", 32'(ev_t), pt);
                chk("ev_spike", 32'(ev_spike), 32'(psp));
            end
            if (ev_valid === 1'b1) evs++;
            if (ev_valid === 1'b1 && ev_spike === 1'b1) fires++;
            chk("spk_cnt0", 32'(spk_cnt0), m0);
            chk("spk_cnt1", 32'(spk_cnt1), m1);

            if (c <= 32) begin
                chk("pe_layer", 32'(pe_layer), l);
                chk("pe_en", 32'(pe_en), (ph == 1 || ph == 2) ? (1 << l) : 0);
                chk("w_addr", 32'(w_addr), (ph == 0) ? l * 2 : l * 2 + 1);
                chk("s_addr", 32'(s_addr), (ph == 0) ? p * 2 : p * 2 + 1);
                if (ph == 1 || ph == 2) begin
                    chk("pe_spike_in", 32'(pe_spike_in), p * 2 + g);
                    chk("pe_weight0", 32'(pe_weight0), (l * 2 + g) * 4);
                    chk("pe_weight3", 32'(pe_weight3), (l * 2 + g) * 4 + 3);
                end
            end else begin
                chk("pe_layer_hold", 32'(pe_layer), 1);
                chk("pe_en_idle", 32'(pe_en), 0);
            end

            if (ph == 3 && c <= 32) begin
                pt = t; pl = l; psp = sp;
                if (sp && l == 0 && m0 < 4) m0++;
                if (sp && l == 1 && m1 < 4) m1++;
            end
            tick();
        end
        start = 1'b0;
        pe_spike_out = 1'b0;
        chk("done_once", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("ev_after", 32'(ev_valid), 0);
        chk("ev_count", evs, 8);
        chk("fire_events", fires, exp_fires);
        chk("final_cnt0", 32'(spk_cnt0), exp_c0);
        chk("final_cnt1", 32'(spk_cnt1), exp_c1);
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        start = 1'b0;
        pe_spike_out = 1'b0;
        tick();
        tick();
        // Reset values.
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pe_en", 32'(pe_en), 0);
        chk("rst_pe_layer", 32'(pe_layer), 0);
        chk("rst_w_addr", 32'(w_addr), 0);
        chk("rst_s_addr", 32'(s_addr), 0);
        chk("rst_ev_valid", 32'(ev_valid), 0);
        chk("rst_cnt0", 32'(spk_cnt0), 0);
        chk("rst_cnt1", 32'(spk_cnt1), 0);

        // start coincident with rst is dropped.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        chk("rst_start_busy2", 32'(busy), 0);
        chk("rst_start_pe_en", 32'(pe_en), 0);

        run(0, 1'b0, 0, 0, 0);   // all zeros, address sequence
        run(2, 1'b0, 0, 1, 1);   // single fire at t=2, layer 1
        run(1, 1'b0, 4, 4, 8);   // always fire: counts saturate at 4
        run(0, 1'b1, 0, 0, 0);   // start re-pulsed mid-run

        // Reset in the ACCUM state of t=1 (cycle 10) with counters non-zero.
        start = 1'b1;
        pe_spike_out = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk("mid_pe_en", 32'(pe_en), 1);
        chk("mid_cnt0", 32'(spk_cnt0), 1);
        chk("mid_cnt1", 32'(spk_cnt1), 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pe_en", 32'(pe_en), 0);
        chk("abort_cnt0", 32'(spk_cnt0), 0);
        chk("abort_cnt1", 32'(spk_cnt1), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ev", 32'(ev_valid), 0);
        rst = 1'b0;
        pe_spike_out = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || ev_valid === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        chk("abort_quiet", dones, 0);

        run(0, 1'b0, 0, 0, 0);   // fresh run after abort

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_pe_scheduler.md
Name: snn_pe_scheduler

Overview:
Sequencer for one dual-layer spiking PE. Sweeps timesteps, then layers, then 4-input groups. For each group it fetches weights and input spikes from synchronous memories and drives the PE accumulate enable. At the end of each layer pass it samples the PE spike output and reports it as a spike event. It also keeps per-layer spike counts for the whole run.

Parameters:
N_IN, 8, inputs per neuron per layer; must be a multiple of 4; N_GROUPS = N_IN/4
N_T, 4, timesteps per run
WA_W, $clog2(2*N_GROUPS), weight memory address width
SA_W, $clog2(N_T*2*N_GROUPS), spike memory address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  run request; single-cycle pulse; ignored while busy
busy  out  1  high from the cycle after an accepted start through the last SAMPLE cycle
done  out  1  one-cycle pulse the cycle after the last SAMPLE
w_addr  out  WA_W  weight memory address; 1-cycle synchronous read
w_rdata  in  32  four 8-bit weights; [7:0] is weight 0 ... [31:24] is weight 3
s_addr  out  SA_W  spike memory address; 1-cycle synchronous read
s_rdata  in  4  four input spikes; bit i is input i
pe_en  out  2  one-hot accumulate enable; bit l selects layer l
pe_layer  out  1  active layer select
pe_spike_in  out  4  equals s_rdata; driven combinationally
pe_weight0..3  out  8 each  slices of w_rdata; driven combinationally
pe_spike_out  in  1  PE fire indication for pe_layer
ev_valid  out  1  spike-event pulse
ev_layer  out  1  layer of the event
ev_t  out  $clog2(N_T)  timestep of the event
ev_spike  out  1  sampled fire bit
spk_cnt0, spk_cnt1  out  $clog2(N_T+1) each  fires counted this run, per layer

Behaviour:
- Reset values: state IDLE; all outputs 0, including the t/l/g counters and both spike counters.
- Reset during a run aborts it: no done pulse, no event output.
- States: IDLE, FETCH, ACCUM, SAMPLE.
- IDLE:
  - start=1: clear spk_cnt0/1 and t, l, g; go to FETCH next cycle.
  - start=0: stay.
- FETCH (1 cycle):
  - w_addr = l*N_GROUPS + 0.
  - s_addr = (t*2 + l)*N_GROUPS + 0.
  - pe_en = 0.
  - Next state ACCUM.
- ACCUM (N_GROUPS cycles, g = 0..N_GROUPS-1):
  - pe_en[l] = 1; pe_layer = l.
  - PE data is the read data from the address issued the previous cycle.
  - Concurrently issue addresses for group g+1; on the last group, hold the addresses.
  - After the last group, go to SAMPLE.
- SAMPLE (1 cycle):
  - pe_en = 0; pe_layer = l. The PE clears its own psum if it fired.
  - Register pe_spike_out into ev_spike; ev_valid = 1 next cycle for exactly 1 cycle, with ev_layer = l and ev_t = t.
  - If pe_spike_out = 1, increment spk_cnt[l], saturating at N_T.
- Advance after SAMPLE:
  - l=0: go to l=1, FETCH.
  - l=1 and t<N_T-1: go to t+1, l=0, FETCH.
  - Otherwise: go to IDLE, with done=1 and busy=0 in that cycle.
- Layer pass length is N_GROUPS+2 cycles. A run takes N_T*2*(N_GROUPS+2) cycles. With defaults, the run occupies cycles 1..32 after the start edge, and done is high in cycle 33.
- pe_layer holds its last value in IDLE. pe_en is 0 outside ACCUM.
- No address may exceed its range. Counters wrap only through the explicit advance rules.
- start coincident with rst: rst wins.

Test Plan:
- Defaults, all spikes and weights 0 -> every ev_spike=0; both spk_cnt=0; exactly 8 ev_valid pulses; done exactly 33 cycles after start.
- Address sequence check (defaults):
  - w_addr per pass = 0,1 for layer 0 and 2,3 for layer 1.
  - s_addr runs 0..15 monotonically across the run.
  - pe_en = 2'b01, 2'b01 then 2'b10, 2'b10 in the respective ACCUM windows.
- Model PE returns pe_spike_out = 1 only in SAMPLE of layer 1, t=2 -> exactly one event with ev_layer=1, ev_t=2, ev_spike=1; spk_cnt1=1, spk_cnt0=0.
- pe_spike_out tied 1 -> spk_cnt0 = spk_cnt1 = 4 (saturates, no wrap).
- start pulsed again at cycle 10 of a run -> ignored; run completes unchanged, a single done at cycle 33.
- rst asserted during the ACCUM state of t=1 -> next cycle: busy=0, pe_en=0, counters 0, no done; a fresh start then completes normally in 33 cycles.
